// File: rtl/ultrasonic_ranger_mc.sv
// ultrasonic_ranger_mc: round-robin multi-channel HC-SR04 ranger.
// One trigger per slot; echo width converted to cm on the fly.
module ultrasonic_ranger_mc #(
  parameter int NUM_CH     = 4,
  parameter int CLK_DIV    = 100,
  parameter int TRIG_US    = 10,
  parameter int US_PER_CM  = 58,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US  = 60000,
  parameter int DIST_W     = 16,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_100m,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        echo,
  output logic [NUM_CH-1:0]        trig,
  output logic [NUM_CH*DIST_W-1:0] dist_cm,
  output logic [NUM_CH-1:0]        timeout,
  output logic                     res_valid,
  output logic [CH_W-1:0]          res_ch,
  output logic [DIST_W-1:0]        res_cm,
  output logic                     res_to,
  output logic                     busy
);

  localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TRG_W  = $clog2(TRIG_US + 1);
  localparam int SLOT_W = $clog2(PERIOD_US + 1);
  localparam int TO_W   = $clog2(TIMEOUT_US + 1);
  localparam int SUB_W  = $clog2(US_PER_CM + 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  state_t state, state_n;

  logic [PRE_W-1:0]  pre;
  logic              tick;
  logic [TRG_W-1:0]  trig_cnt;
  logic [SLOT_W-1:0] slot_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [SUB_W-1:0]  sub_cnt;
  logic [DIST_W-1:0] cm;
  logic [CH_W-1:0]   ch, ch_nx, ch_n;

  logic [NUM_CH-1:0] s1, s2, hist;
  logic              rise, fall;

  logic emit, emit_to;
  logic clr_slot, clr_to, clr_meas, adv;
  logic trig_done, slot_done, to_hit;
  logic [DIST_W-1:0] res_val;

  assign tick = (pre == PRE_W'(CLK_DIV - 1));

  always_ff @(posedge clk_100m) begin
    if (rst) pre <= '0;
    else     pre <= tick ? '0 : pre + 1'b1;
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      hist <= '0;
    end else begin
      s1   <= echo;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign rise = s2[ch] & ~hist[ch];
  assign fall = ~s2[ch] & hist[ch];

  assign trig_done = tick && (trig_cnt == TRG_W'(TRIG_US - 1));
  assign slot_done = tick && (slot_cnt >= SLOT_W'(PERIOD_US - 1));
  assign to_hit    = tick && (to_cnt >= TO_W'(TIMEOUT_US - 1));

  assign ch_nx   = (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
  assign ch_n    = adv ? ch_nx : ch;
  assign res_val = emit_to ? {DIST_W{1'b1}} : cm;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk_100m) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    emit     = 1'b0;
    emit_to  = 1'b0;
    clr_slot = 1'b0;
    clr_to   = 1'b0;
    clr_meas = 1'b0;
    adv      = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && tick) begin
          state_n  = TRIG;
          clr_slot = 1'b1;
        end
      end
      TRIG: begin
        if (trig_done) begin
          state_n = WAIT_RISE;
          clr_to  = 1'b1;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          state_n  = MEASURE;
          clr_meas = 1'b1;
        end else if (to_hit) begin
          state_n = HOLDOFF;
          emit    = 1'b1;
          emit_to = 1'b1;
        end
      end
      MEASURE: begin
        // fall takes priority over a coincident timeout
        if (fall) begin
          state_n = HOLDOFF;
          emit    = 1'b1;
        end else if (to_hit) begin
          state_n = HOLDOFF;
          emit    = 1'b1;
          emit_to = 1'b1;
        end
      end
      HOLDOFF: begin
        if (slot_done) begin
          adv      = 1'b1;
          state_n  = enable ? TRIG : IDLE;
          clr_slot = enable;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      ch       <= '0;
      trig_cnt <= '0;
      slot_cnt <= '0;
      to_cnt   <= '0;
      sub_cnt  <= '0;
      cm       <= '0;
      trig     <= '0;
    end else begin
      ch   <= ch_n;
      trig <= (state_n == TRIG) ? (NUM_CH'(1) << ch_n) : '0;

      if (state != TRIG) trig_cnt <= '0;
      else if (tick)     trig_cnt <= trig_cnt + 1'b1;

      if (clr_slot)
        slot_cnt <= '0;
      else if (state != IDLE && tick && slot_cnt != '1)
        slot_cnt <= slot_cnt + 1'b1;

      if (clr_to)
        to_cnt <= '0;
      else if ((state == WAIT_RISE || state == MEASURE) && tick)
        to_cnt <= to_cnt + 1'b1;

      if (clr_meas) begin
        sub_cnt <= '0;
        cm      <= '0;
      end else if (state == MEASURE && tick) begin
        if (sub_cnt == SUB_W'(US_PER_CM - 1)) begin
          sub_cnt <= '0;
          if (cm != '1) cm <= cm + 1'b1;
        end else begin
          sub_cnt <= sub_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_cm    <= '0;
      res_to    <= 1'b0;
      dist_cm   <= '0;
      timeout   <= '0;
    end else begin
      res_valid <= emit;
      if (emit) begin
        res_ch  <= ch;
        res_cm  <= res_val;
        res_to  <= emit_to;
        dist_cm[int'(ch)*DIST_W +: DIST_W] <= res_val;
        timeout[ch] <= emit_to;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// tb_ultrasonic_ranger_mc: directed scenarios with a result scoreboard.
// Expected results are queued by stimulus and popped by the monitor.
module tb_ultrasonic_ranger_mc;

  localparam int NCH = 2;
  localparam int DW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [NCH-1:0]    echo = '0;
  logic [NCH-1:0]    trig, timeout;
  logic [NCH*DW-1:0] dist_cm;
  logic              res_valid, res_to, busy;
  logic [0:0]        res_ch;
  logic [DW-1:0]     res_cm;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  typedef struct packed {
    logic [0:0]    ch;
    logic [DW-1:0] cm;
    logic          to;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  ultrasonic_ranger_mc #(
    .NUM_CH(NCH), .CLK_DIV(4), .TRIG_US(10), .US_PER_CM(58),
    .TIMEOUT_US(1000), .PERIOD_US(2000), .DIST_W(DW)
  ) dut (
    .clk_100m(clk), .rst(rst), .enable(enable), .echo(echo),
    .trig(trig), .dist_cm(dist_cm), .timeout(timeout),
    .res_valid(res_valid), .res_ch(res_ch), .res_cm(res_cm),
    .res_to(res_to), .busy(busy)
  );

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (res_valid) begin
      if (q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = q.pop_front();
        check("res_ch", res_ch, e.ch);
        check("res_cm", res_cm, e.cm);
        check("res_to", res_to, e.to);
        check("dist_cm_ch", dist_cm[int'(e.ch)*DW +: DW], e.cm);
        check("timeout_ch", timeout[e.ch], e.to);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_trig(int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (trig != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic trig_width(output int w, output bit other);
    logic [NCH-1:0] m;
    m = trig;
    w = 0;
    other = 1'b0;
    while (trig != '0 && w < 1000) begin
      w++;
      if (trig != m) other = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic wait_res(int lim, output int k);
    k = 0;
    while (k < lim) begin
      @(negedge clk);
      k++;
      if (res_valid) break;
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_trig"}, trig, 0);
    check({tag, "_dist"}, dist_cm, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_ch"}, res_ch, 0);
    check({tag, "_res_cm"}, res_cm, 0);
    check({tag, "_res_to"}, res_to, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin : stim
    bit ok, other;
    int w, k, t0, t1;
    logic any_trig, any_busy;

    rst = 1'b1;
    cyc(3);
    check_zero("reset");
    rst = 1'b0;
    enable = 1'b1;

    // ch0: echo 580 us, starting 100 us after trigger fall
    wait_trig(100, ok);
    check("trig0_start", ok, 1);
    t0 = cyc_n;
    check("trig0_sel", trig, 2'b01);
    check("busy_run", busy, 1);
    trig_width(w, other);
    check("trig0_width", w, 40);
    check("trig0_other", other, 0);
    q.push_back(exp_t'{1'b0, 16'd10, 1'b0});
    cyc(399);
    echo[0] = 1'b1;
    cyc(2320);
    echo[0] = 1'b0;

    // ch1: no echo, timeout 1000 us after trigger fall
    wait_trig(10000, ok);
    check("trig1_start", ok, 1);
    t1 = cyc_n;
    check("slot_period", t1 - t0, 8000);
    check("trig1_sel", trig, 2'b10);
    check("dist0_after", dist_cm[DW-1:0], 10);
    check("timeout0_after", timeout[0], 0);
    trig_width(w, other);
    check("trig1_width", w, 40);
    q.push_back(exp_t'{1'b1, 16'hFFFF, 1'b1});
    wait_res(5000, k);
    check("timeout_latency", k, 4000);
    check("dist0_kept", dist_cm[DW-1:0], 10);

    // ch0 again with echo stuck high before trigger
    echo[0] = 1'b1;
    wait_trig(10000, ok);
    check("wrap_start", ok, 1);
    check("wrap_sel", trig, 2'b01);
    trig_width(w, other);
    q.push_back(exp_t'{1'b0, 16'hFFFF, 1'b1});
    cyc(2000);
    echo[0] = 1'b0;
    wait_res(5000, k);
    check("stuck_latency", k + 2000, 4000);

    // ch1: enable dropped mid-measure
    wait_trig(10000, ok);
    check("trig1b_sel", trig, 2'b10);
    trig_width(w, other);
    q.push_back(exp_t'{1'b1, 16'd10, 1'b0});
    cyc(399);
    echo[1] = 1'b1;
    cyc(100);
    enable = 1'b0;
    cyc(2220);
    echo[1] = 1'b0;
    wait_res(1000, k);
    check("drop_result", res_valid, 1);
    k = 0;
    while (busy && k < 10000) begin
      cyc(1);
      k++;
    end
    check("drop_idle", busy, 0);
    any_trig = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1);
      any_trig |= |trig;
      any_busy |= busy;
    end
    check("idle_no_trig", any_trig, 0);
    check("idle_no_busy", any_busy, 0);

    // ch0: reset during measure
    enable = 1'b1;
    wait_trig(100, ok);
    check("restart_sel", trig, 2'b01);
    trig_width(w, other);
    cyc(399);
    echo[0] = 1'b1;
    cyc(200);
    rst = 1'b1;
    cyc(1);
    check_zero("midrst");
    enable = 1'b0;
    echo = '0;
    cyc(5);
    rst = 1'b0;
    cyc(2000);
    check("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
